// File: rtl/apb_mon_pkg.sv
// apb_mon_pkg: shared types and constants for the APB4 protocol monitor.
//   apb_state_e - monitor FSM state (IDLE / SETUP / ACCESS)
//   ERR_W       - width of the error flag vectors
//   ERR_*       - bit index of each protocol violation in the error vectors
package apb_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } apb_state_e;

  localparam int ERR_W = 8;

  localparam int ERR_MULTI_SEL       = 0;
  localparam int ERR_ENABLE_NO_SETUP = 1;
  localparam int ERR_NO_ACCESS       = 2;
  localparam int ERR_UNSTABLE        = 3;
  localparam int ERR_READ_STRB       = 4;
  localparam int ERR_PENABLE_DROP    = 5;
  localparam int ERR_TIMEOUT         = 6;

endpackage

// File: rtl/apb_protocol_monitor_if.sv
// apb_protocol_monitor_if: APB4 bus bundle for one segment.
//   PSEL[NUM_SLV]              slave selects
//   PENABLE, PWRITE            phase / direction
//   PADDR[ADDR_W]              address
//   PWDATA/PRDATA[DATA_W]      write / read data
//   PSTRB[DATA_W/8]            write strobes
//   PREADY, PSLVERR            slave response
// Modports: master (requester), slave (completer), monitor (observe only).
interface apb_protocol_monitor_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 1
);
  localparam int STRB_W = DATA_W / 8;

  logic [NUM_SLV-1:0] PSEL;
  logic               PENABLE;
  logic               PWRITE;
  logic [ADDR_W-1:0]  PADDR;
  logic [DATA_W-1:0]  PWDATA;
  logic [STRB_W-1:0]  PSTRB;
  logic [DATA_W-1:0]  PRDATA;
  logic               PREADY;
  logic               PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );

  modport monitor (
    input PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
          PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_mon_err_log.sv
// apb_mon_err_log: registers the per-edge error vector of the monitor.
//   clk, rst_n   clock, async active-low reset
//   err_in       violations detected on the current sampling edge
//   err_clr      clears sticky flags and counter
//   err_pulse    err_in delayed one cycle
//   err_sticky   OR-accumulation of err_in since last clear
//   err_cnt      saturating count of edges with any error
// A new error on the clearing edge is kept: the clear only drops history.
module apb_mon_err_log
  import apb_mon_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ERR_W-1:0] err_in,
  input  logic             err_clr,
  output logic [ERR_W-1:0] err_pulse,
  output logic [ERR_W-1:0] err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  logic any_err;
  assign any_err = |err_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse  <= '0;
      err_sticky <= '0;
      err_cnt    <= '0;
    end else begin
      err_pulse <= err_in;
      if (err_clr) begin
        err_sticky <= err_in;
        err_cnt    <= any_err ? CNT_W'(1) : '0;
      end else begin
        err_sticky <= err_sticky | err_in;
        if (any_err && (err_cnt != '1))
          err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/apb_protocol_monitor.sv
// apb_protocol_monitor: passive APB4 protocol checker for one bus segment.
//   PCLK, PRESETn        bus clock, async active-low reset
//   bus (monitor)        observed APB signals
//   err_clr              clears err_sticky / err_cnt
//   err_pulse[8]         violations seen on the previous edge
//   err_sticky[8]        accumulated violations
//   err_cnt[CNT_W]       saturating count of erroring cycles
//   xfer_done            one-cycle pulse per completed transfer
//   xfer_write/slverr/addr/data/sel  record of the last completed transfer
// Optional feature: define APB_MON_TIMEOUT_EN to build the wait-state counter
// and the TIMEOUT check (bit 6); otherwise bit 6 is tied low.
module apb_protocol_monitor
  import apb_mon_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_SLV     = 1,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  apb_protocol_monitor_if.monitor bus,
  input  logic                   err_clr,
  output logic [ERR_W-1:0]       err_pulse,
  output logic [ERR_W-1:0]       err_sticky,
  output logic [CNT_W-1:0]       err_cnt,
  output logic                   xfer_done,
  output logic                   xfer_write,
  output logic                   xfer_slverr,
  output logic [ADDR_W-1:0]      xfer_addr,
  output logic [DATA_W-1:0]      xfer_data,
  output logic [NUM_SLV-1:0]     xfer_sel
);

  localparam int STRB_W = DATA_W / 8;

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("apb_protocol_monitor: TIMEOUT_CYC must be >= 1");
  end
  if ((DATA_W % 8) != 0) begin : g_bad_data_w
    $error("apb_protocol_monitor: DATA_W must be a multiple of 8");
  end

  apb_state_e         state;
  logic [NUM_SLV-1:0] cap_sel;
  logic [ADDR_W-1:0]  cap_addr;
  logic               cap_write;
  logic [DATA_W-1:0]  cap_wdata;
  logic [STRB_W-1:0]  cap_strb;

  logic             in_xfer;   // FSM is past the setup edge
  logic             cap_en;    // a setup phase is sampled this edge
  logic             complete;  // transfer completes this edge
  logic             mismatch;
  logic [ERR_W-1:0] err_now;

`ifdef APB_MON_TIMEOUT_EN
  localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WCNT_W-1:0] TMO = WCNT_W'(TIMEOUT_CYC);
  logic [WCNT_W-1:0] wait_cnt;
  logic [WCNT_W-1:0] wait_nxt;
`endif

  assign in_xfer  = (state == ST_SETUP) || (state == ST_ACCESS);
  assign cap_en   = !bus.PENABLE && (|bus.PSEL) &&
                    ((state == ST_IDLE) || (state == ST_SETUP));
  assign complete = in_xfer && bus.PENABLE && bus.PREADY;

  always_comb begin
    err_now  = '0;
    // Data and strobes are only meaningful to hold steady on writes.
    mismatch = (bus.PSEL != cap_sel) || (bus.PADDR != cap_addr) ||
               (bus.PWRITE != cap_write) ||
               (cap_write && ((bus.PWDATA != cap_wdata) ||
                              (bus.PSTRB != cap_strb)));

    // x & (x-1) is non-zero iff more than one bit is set.
    err_now[ERR_MULTI_SEL]       = |(bus.PSEL & (bus.PSEL - NUM_SLV'(1)));
    err_now[ERR_ENABLE_NO_SETUP] = (state == ST_IDLE) && bus.PENABLE;
    err_now[ERR_NO_ACCESS]       = (state == ST_SETUP) && !bus.PENABLE;
    err_now[ERR_UNSTABLE]        = in_xfer && bus.PENABLE && mismatch;
    err_now[ERR_READ_STRB]       = (|bus.PSEL) && !bus.PWRITE && (|bus.PSTRB);
    err_now[ERR_PENABLE_DROP]    = (state == ST_ACCESS) && !bus.PENABLE;

`ifdef APB_MON_TIMEOUT_EN
    // Counter tracks wait edges of the current transfer and parks at TMO,
    // so the timeout fires exactly once per stalled transfer.
    wait_nxt = '0;
    if ((state == ST_SETUP) && bus.PENABLE && !bus.PREADY)
      wait_nxt = WCNT_W'(1);
    else if ((state == ST_ACCESS) && bus.PENABLE && !bus.PREADY)
      wait_nxt = (wait_cnt == TMO) ? wait_cnt : wait_cnt + WCNT_W'(1);
    err_now[ERR_TIMEOUT] = (wait_nxt == TMO) && (wait_cnt != TMO);
`endif
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= ST_IDLE;
`ifdef APB_MON_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
`ifdef APB_MON_TIMEOUT_EN
      wait_cnt <= wait_nxt;
`endif
      case (state)
        ST_IDLE:   if (cap_en) state <= ST_SETUP;
        ST_SETUP:
          if (!bus.PENABLE) state <= (|bus.PSEL) ? ST_SETUP : ST_IDLE;
          else              state <= bus.PREADY ? ST_IDLE : ST_ACCESS;
        ST_ACCESS: if (!bus.PENABLE || bus.PREADY) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cap_sel     <= '0;
      cap_addr    <= '0;
      cap_write   <= 1'b0;
      cap_wdata   <= '0;
      cap_strb    <= '0;
      xfer_done   <= 1'b0;
      xfer_write  <= 1'b0;
      xfer_slverr <= 1'b0;
      xfer_addr   <= '0;
      xfer_data   <= '0;
      xfer_sel    <= '0;
    end else begin
      xfer_done <= complete;
      if (cap_en) begin
        cap_sel   <= bus.PSEL;
        cap_addr  <= bus.PADDR;
        cap_write <= bus.PWRITE;
        cap_wdata <= bus.PWDATA;
        cap_strb  <= bus.PSTRB;
      end
      if (complete) begin
        xfer_write  <= cap_write;
        xfer_slverr <= bus.PSLVERR;
        xfer_addr   <= cap_addr;
        xfer_data   <= cap_write ? cap_wdata : bus.PRDATA;
        xfer_sel    <= cap_sel;
      end
    end
  end

  apb_mon_err_log #(.CNT_W(CNT_W)) u_err_log (
    .clk        (PCLK),
    .rst_n      (PRESETn),
    .err_in     (err_now),
    .err_clr    (err_clr),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

endmodule
